// File: rtl/fall_scheduler.sv
// fall_scheduler: gravity, soft-drop, hard-drop and lock sequencing with level and speed tracking.
// Build option: define FALL_SCHEDULER_HARD_DROP_EN to include the HARD state and honour hard_drop.
module fall_scheduler #(
   parameter int LOCK_TICKS      = 8,
   parameter int SOFT_DIV        = 4,
   parameter int LINES_PER_LEVEL = 10,
   parameter int SPEED_STEP      = 7,
   parameter int FALL_MAX        = 75
) (
   input  logic       Clk,
   input  logic       Reset,
   input  logic       fall_tick,
   input  logic       spawn,
   input  logic       can_down,
   input  logic       soft_drop,
   input  logic       hard_drop,
   input  logic       clear_done,
   input  logic [2:0] lines_cleared,
   output logic       move_down,
   output logic       lock_piece,
   output logic [6:0] Fall_Count,
   output logic [3:0] level,
   output logic       game_over
);

   localparam int LCW = $clog2(LOCK_TICKS + 1);
   localparam int SCW = $clog2(SOFT_DIV + 1);

   typedef enum logic [2:0] {
      IDLE, FALL, HARD, GROUNDED, LOCK, CLEAR, OVER
   } state_t;

   state_t         state, state_nxt;
   logic [LCW-1:0] lock_cnt;
   logic [SCW-1:0] soft_cnt;
   logic [4:0]     line_acc;
   logic [5:0]     acc_sum;
   logic           hard_req, soft_step, step, lock_due, level_up;
   logic           move_down_nxt, lock_piece_nxt;

   function automatic logic [6:0] sat_fall_count(input logic [6:0] cur);
      int sum;
      sum = int'(cur) + SPEED_STEP;
      return (sum > FALL_MAX) ? 7'(FALL_MAX) : 7'(sum);
   endfunction

   function automatic logic [3:0] sat_level(input logic [3:0] cur);
      return (cur == 4'hF) ? cur : cur + 4'd1;
   endfunction

`ifdef FALL_SCHEDULER_HARD_DROP_EN
   assign hard_req = hard_drop;
`else
   logic unused_hard_drop;
   assign unused_hard_drop = hard_drop;
   assign hard_req         = 1'b0;
`endif

   // Gravity tick and soft-divider wrap merge into a single step event.
   assign soft_step = soft_drop && (soft_cnt == SCW'(SOFT_DIV - 1));
   assign step      = fall_tick || soft_step;
   assign lock_due  = fall_tick && (lock_cnt == LCW'(LOCK_TICKS - 1));
   assign acc_sum   = {1'b0, line_acc} + {3'b000, lines_cleared};
   assign level_up  = (acc_sum >= 6'(LINES_PER_LEVEL));

   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (spawn) state_nxt = can_down ? FALL : OVER;
         FALL: begin
            if (hard_req)               state_nxt = HARD;
            else if (step && !can_down) state_nxt = GROUNDED;
         end
`ifdef FALL_SCHEDULER_HARD_DROP_EN
         HARD:     if (!can_down) state_nxt = LOCK;
`endif
         GROUNDED: begin
            if (can_down)                  state_nxt = FALL;
            else if (hard_req || lock_due) state_nxt = LOCK;
         end
         LOCK:     state_nxt = CLEAR;
         CLEAR:    if (clear_done) state_nxt = IDLE;
         OVER:     state_nxt = OVER;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      move_down_nxt = 1'b0;
      case (state)
         FALL:    move_down_nxt = step && can_down && !hard_req;
`ifdef FALL_SCHEDULER_HARD_DROP_EN
         HARD:    move_down_nxt = can_down;
`endif
         default: move_down_nxt = 1'b0;
      endcase
      lock_piece_nxt = (state_nxt == LOCK);
   end

   // Outputs are registered copies of the decoded next values; counters live here too.
   always_ff @(posedge Clk or posedge Reset) begin
      if (Reset) begin
         move_down  <= 1'b0;
         lock_piece <= 1'b0;
         game_over  <= 1'b0;
         lock_cnt   <= '0;
         soft_cnt   <= '0;
         line_acc   <= '0;
         level      <= '0;
         Fall_Count <= '0;
      end else begin
         move_down  <= move_down_nxt;
         lock_piece <= lock_piece_nxt;
         game_over  <= (state_nxt == OVER);

         if (state != FALL || !soft_drop || soft_step) soft_cnt <= '0;
         else                                           soft_cnt <= soft_cnt + SCW'(1);

         if (state != GROUNDED || can_down) lock_cnt <= '0;
         else if (fall_tick)                lock_cnt <= lock_cnt + LCW'(1);

         if (state == CLEAR && clear_done) begin
            if (level_up) begin
               line_acc   <= 5'(acc_sum - 6'(LINES_PER_LEVEL));
               level      <= sat_level(level);
               Fall_Count <= sat_fall_count(Fall_Count);
            end else begin
               line_acc   <= acc_sum[4:0];
            end
         end
      end
   end

endmodule

// File: tb/tb_fall_scheduler.sv
// Self-checking bench for fall_scheduler: directed scenarios with randomized timing and line counts.
module tb_fall_scheduler;

   localparam int LOCK_TICKS = 8;
   localparam int SOFT_DIV   = 4;
   localparam int LPL        = 10;
   localparam int SPEED_STEP = 7;
   localparam int FALL_MAX   = 75;

`ifdef FALL_SCHEDULER_HARD_DROP_EN
   localparam bit HD_EN = 1'b1;
`else
   localparam bit HD_EN = 1'b0;
`endif

   logic       Clk = 1'b0;
   logic       Reset = 1'b0;
   logic       fall_tick = 1'b0;
   logic       spawn = 1'b0;
   logic       can_down = 1'b0;
   logic       soft_drop = 1'b0;
   logic       hard_drop = 1'b0;
   logic       clear_done = 1'b0;
   logic [2:0] lines_cleared = 3'd0;
   logic       move_down, lock_piece, game_over;
   logic [6:0] Fall_Count;
   logic [3:0] level;

   int n_checks = 0;
   int n_pass   = 0;

   fall_scheduler #(
      .LOCK_TICKS(LOCK_TICKS), .SOFT_DIV(SOFT_DIV), .LINES_PER_LEVEL(LPL),
      .SPEED_STEP(SPEED_STEP), .FALL_MAX(FALL_MAX)
   ) dut (
      .Clk(Clk), .Reset(Reset), .fall_tick(fall_tick), .spawn(spawn),
      .can_down(can_down), .soft_drop(soft_drop), .hard_drop(hard_drop),
      .clear_done(clear_done), .lines_cleared(lines_cleared),
      .move_down(move_down), .lock_piece(lock_piece), .Fall_Count(Fall_Count),
      .level(level), .game_over(game_over)
   );

   always #5 Clk = ~Clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic step_clk();
      @(posedge Clk);
      #1;
   endtask

   task automatic clear_inputs();
      fall_tick = 0; spawn = 0; can_down = 0; soft_drop = 0;
      hard_drop = 0; clear_done = 0; lines_cleared = 0;
   endtask

   task automatic do_reset();
      clear_inputs();
      Reset = 1;
      step_clk();
      Reset = 0;
   endtask

   task automatic spawn_piece(input logic cd);
      spawn = 1; can_down = cd;
      step_clk();
      spawn = 0;
   endtask

   task automatic ground();
      can_down = 0; fall_tick = 1;
      step_clk();
      fall_tick = 0;
   endtask

   task automatic place_piece(input int lines);
      spawn_piece(1'b1);
      ground();
      for (int n = 0; n < LOCK_TICKS; n++) begin
         fall_tick = 1;
         step_clk();
      end
      fall_tick = 0;
      step_clk();
      repeat ($urandom_range(0, 3)) step_clk();
      clear_done = 1; lines_cleared = 3'(lines);
      step_clk();
      clear_done = 0; lines_cleared = 3'($urandom_range(0, 7));
   endtask

   task automatic test_reset();
      #2 Reset = 1;
      step_clk();
      n_checks++;
      if ({move_down, lock_piece, game_over, level, Fall_Count} !== 14'd0)
         $display("FAIL reset_outputs: md=%b lp=%b go=%b lvl=%0d fc=%0d expected all 0",
                  move_down, lock_piece, game_over, level, Fall_Count);
      else n_pass++;
      Reset = 0;
      // asynchronous reset clears a live move_down pulse before the next edge
      spawn_piece(1'b1);
      can_down = 1; fall_tick = 1;
      step_clk();
      fall_tick = 0;
      n_checks++;
      if (move_down !== 1'b1) $display("FAIL reset_pre_pulse: move_down=%b expected 1", move_down);
      else n_pass++;
      Reset = 1;
      #1;
      n_checks++;
      if (move_down !== 1'b0) $display("FAIL reset_async: move_down=%b expected 0", move_down);
      else n_pass++;
      step_clk();
      Reset = 0;
      // reset mid-GROUNDED, then a fresh grounding needs the full tick budget
      spawn_piece(1'b1);
      ground();
      for (int n = 0; n < LOCK_TICKS - 1; n++) begin fall_tick = 1; step_clk(); end
      fall_tick = 0;
      do_reset();
      spawn_piece(1'b1);
      ground();
      for (int n = 1; n <= LOCK_TICKS; n++) begin
         fall_tick = 1;
         step_clk();
         n_checks++;
         if (lock_piece !== (n == LOCK_TICKS))
            $display("FAIL reset_grounded_tick%0d: lock_piece=%b expected %b", n, lock_piece, n == LOCK_TICKS);
         else n_pass++;
      end
      fall_tick = 0;
   endtask

   task automatic test_gravity();
      do_reset();
      spawn_piece(1'b1);
      can_down = 1;
      for (int i = 0; i < 3; i++) begin
         repeat ($urandom_range(0, 4)) begin
            step_clk();
            n_checks++;
            if (move_down !== 1'b0) $display("FAIL gravity_idle%0d: move_down=%b expected 0", i, move_down);
            else n_pass++;
         end
         fall_tick = 1;
         step_clk();
         fall_tick = 0;
         n_checks++;
         if (move_down !== 1'b1) $display("FAIL gravity_pulse%0d: move_down=%b expected 1", i, move_down);
         else n_pass++;
      end
      step_clk();
      n_checks++;
      if (move_down !== 1'b0) $display("FAIL gravity_end: move_down=%b expected 0", move_down);
      else n_pass++;
   endtask

   task automatic test_lock();
      do_reset();
      spawn_piece(1'b1);
      ground();
      for (int n = 1; n <= LOCK_TICKS; n++) begin
         repeat ($urandom_range(0, 3)) begin
            step_clk();
            n_checks++;
            if (lock_piece !== 1'b0) $display("FAIL lock_gap%0d: lock_piece=%b expected 0", n, lock_piece);
            else n_pass++;
         end
         fall_tick = 1;
         step_clk();
         fall_tick = 0;
         n_checks++;
         if (lock_piece !== (n == LOCK_TICKS))
            $display("FAIL lock_tick%0d: lock_piece=%b expected %b", n, lock_piece, n == LOCK_TICKS);
         else n_pass++;
      end
      step_clk();
      n_checks++;
      if (lock_piece !== 1'b0) $display("FAIL lock_one_cycle: lock_piece=%b expected 0", lock_piece);
      else n_pass++;

      // piece freed on tick 5 returns to falling; a later grounding restarts the count
      do_reset();
      spawn_piece(1'b1);
      ground();
      for (int n = 0; n < 4; n++) begin fall_tick = 1; step_clk(); end
      can_down = 1;
      step_clk();
      fall_tick = 0;
      n_checks++;
      if ({lock_piece, move_down} !== 2'b00)
         $display("FAIL lock_release: lp=%b md=%b expected 0 0", lock_piece, move_down);
      else n_pass++;
      for (int n = 0; n < 10; n++) begin
         fall_tick = 1;
         step_clk();
         n_checks++;
         if ({lock_piece, move_down} !== 2'b01)
            $display("FAIL lock_refall%0d: lp=%b md=%b expected 0 1", n, lock_piece, move_down);
         else n_pass++;
      end
      fall_tick = 0;
      ground();
      for (int n = 1; n <= LOCK_TICKS; n++) begin
         fall_tick = 1;
         step_clk();
         n_checks++;
         if (lock_piece !== (n == LOCK_TICKS))
            $display("FAIL lock_regrounded%0d: lock_piece=%b expected %b", n, lock_piece, n == LOCK_TICKS);
         else n_pass++;
      end
      fall_tick = 0;
   endtask

   task automatic test_soft_drop(input int k);
      do_reset();
      spawn_piece(1'b1);
      can_down = 1; soft_drop = 1;
      for (int i = 1; i <= SOFT_DIV * k; i++) begin
         step_clk();
         n_checks++;
         if (move_down !== ((i % SOFT_DIV) == 0))
            $display("FAIL soft_clock%0d: move_down=%b expected %b", i, move_down, (i % SOFT_DIV) == 0);
         else n_pass++;
      end
      soft_drop = 0;
      step_clk();
      n_checks++;
      if (move_down !== 1'b0) $display("FAIL soft_release: move_down=%b expected 0", move_down);
      else n_pass++;
   endtask

   task automatic test_soft_restart();
      int pulses;
      do_reset();
      spawn_piece(1'b1);
      can_down = 1;
      pulses = 0;
      soft_drop = 1;
      repeat (SOFT_DIV - 1) begin step_clk(); pulses += int'(move_down); end
      soft_drop = 0;
      step_clk(); pulses += int'(move_down);
      soft_drop = 1;
      repeat (SOFT_DIV - 1) begin step_clk(); pulses += int'(move_down); end
      n_checks++;
      if (pulses !== 0) $display("FAIL soft_restart_quiet: pulses=%0d expected 0", pulses);
      else n_pass++;
      step_clk();
      n_checks++;
      if (move_down !== 1'b1) $display("FAIL soft_restart_step: move_down=%b expected 1", move_down);
      else n_pass++;
      soft_drop = 0;
   endtask

   task automatic test_hard_drop(input int n, input logic with_tick);
      do_reset();
      spawn_piece(1'b1);
      can_down = 1; hard_drop = 1; fall_tick = with_tick;
      step_clk();
      hard_drop = 0; fall_tick = 0;
      n_checks++;
      if (move_down !== (with_tick && !HD_EN))
         $display("FAIL hard_entry: move_down=%b expected %b", move_down, with_tick && !HD_EN);
      else n_pass++;
      for (int i = 0; i < n; i++) begin
         step_clk();
         n_checks++;
         if (move_down !== HD_EN) $display("FAIL hard_move%0d: move_down=%b expected %b", i, move_down, HD_EN);
         else n_pass++;
      end
      can_down = 0;
      step_clk();
      n_checks++;
      if ({lock_piece, move_down} !== {HD_EN, 1'b0})
         $display("FAIL hard_lock: lp=%b md=%b expected %b 0", lock_piece, move_down, HD_EN);
      else n_pass++;
      step_clk();
      n_checks++;
      if (lock_piece !== 1'b0) $display("FAIL hard_lock_once: lock_piece=%b expected 0", lock_piece);
      else n_pass++;
   endtask

   task automatic test_levels();
      int total, ups, exp_lvl, exp_fc, lines;
      do_reset();
      clear_done = 1; lines_cleared = 3'd4;
      step_clk();
      clear_done = 0;
      total = 0;
      for (int p = 0; p < 200 && total < 165; p++) begin
         lines = (p < 5) ? 4 : int'($urandom_range(0, 4));
         place_piece(lines);
         total += lines;
         ups     = total / LPL;
         exp_lvl = (ups > 15) ? 15 : ups;
         exp_fc  = (ups * SPEED_STEP > FALL_MAX) ? FALL_MAX : ups * SPEED_STEP;
         n_checks++;
         if (int'(level) !== exp_lvl)
            $display("FAIL level_p%0d: level=%0d expected %0d (lines=%0d)", p, level, exp_lvl, total);
         else n_pass++;
         n_checks++;
         if (int'(Fall_Count) !== exp_fc)
            $display("FAIL fall_count_p%0d: Fall_Count=%0d expected %0d (lines=%0d)", p, Fall_Count, exp_fc, total);
         else n_pass++;
      end
   endtask

   task automatic test_game_over();
      do_reset();
      spawn_piece(1'b0);
      n_checks++;
      if (game_over !== 1'b1) $display("FAIL game_over_set: game_over=%b expected 1", game_over);
      else n_pass++;
      for (int i = 0; i < 20; i++) begin
         spawn = 1'($urandom_range(0, 1)); hard_drop = 1'($urandom_range(0, 1));
         fall_tick = 1'($urandom_range(0, 1)); can_down = 1'($urandom_range(0, 1));
         soft_drop = 1'($urandom_range(0, 1)); clear_done = 1'($urandom_range(0, 1));
         lines_cleared = 3'd4;
         step_clk();
         n_checks++;
         if ({game_over, move_down, lock_piece, level} !== {3'b100, 4'd0})
            $display("FAIL over_sticky%0d: go=%b md=%b lp=%b lvl=%0d expected 1 0 0 0",
                     i, game_over, move_down, lock_piece, level);
         else n_pass++;
      end
      clear_inputs();
      Reset = 1;
      #1;
      n_checks++;
      if (game_over !== 1'b0) $display("FAIL over_reset: game_over=%b expected 0", game_over);
      else n_pass++;
      step_clk();
      Reset = 0;
      spawn_piece(1'b1);
      can_down = 1; fall_tick = 1;
      step_clk();
      fall_tick = 0;
      n_checks++;
      if ({game_over, move_down} !== 2'b01)
         $display("FAIL over_restart: go=%b md=%b expected 0 1", game_over, move_down);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_gravity();
      test_lock();
      test_soft_drop(3);
      test_soft_drop(int'($urandom_range(1, 4)));
      test_soft_restart();
      test_hard_drop(5, 1'b0);
      test_hard_drop(int'($urandom_range(1, 6)), 1'b1);
      test_levels();
      test_game_over();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/fall_scheduler.md
FALL_SCHEDULER -- requirements
Module: fall_scheduler

Interface
REQ-001 SHALL have parameter LOCK_TICKS, default 8: fall_tick pulses tolerated grounded before lock.
REQ-002 SHALL have parameter SOFT_DIV, default 4: clocks per soft-drop step.
REQ-003 SHALL have parameter LINES_PER_LEVEL, default 10: cleared lines per level-up.
REQ-004 SHALL have parameter SPEED_STEP, default 7: Fall_Count increment per level.
REQ-005 SHALL have parameter FALL_MAX, default 75: Fall_Count saturation value.
REQ-006 Clk  input  1  system clock, all state on rising edge.
REQ-007 Reset  input  1  asynchronous, active-high reset.
REQ-008 fall_tick  input  1  one-cycle gravity pulse, synchronous to Clk.
REQ-009 spawn  input  1  one-cycle pulse: new piece placed.
REQ-010 can_down  input  1  collision result: active piece may move down one row.
REQ-011 soft_drop  input  1  level: soft-drop key held.
REQ-012 hard_drop  input  1  one-cycle pulse: hard-drop request.
REQ-013 clear_done  input  1  one-cycle pulse: line clear finished.
REQ-014 lines_cleared  input  3  rows removed, valid with clear_done, range 0-4.
REQ-015 move_down  output  1  one-cycle pulse: shift piece down one row.
REQ-016 lock_piece  output  1  one-cycle pulse: write piece into board.
REQ-017 Fall_Count  output  7  gravity speed to frame-tick generator.
REQ-018 level  output  4  current level.
REQ-019 game_over  output  1  sticky: spawn while blocked.

Function
REQ-020 States SHALL be IDLE, FALL, HARD, GROUNDED, LOCK, CLEAR, OVER; all outputs registered.
REQ-021 IDLE: spawn & can_down -> FALL; spawn & !can_down -> OVER; else stay.
REQ-022 FALL: step event = fall_tick, or soft-divider terminal count while soft_drop=1; coincident sources SHALL yield one step.
REQ-023 FALL step with can_down=1 SHALL pulse move_down next cycle; with can_down=0 SHALL enter GROUNDED, lock counter cleared.
REQ-024 Soft divider SHALL count 0..SOFT_DIV-1, clear when soft_drop=0 or on state entry.
REQ-025 FALL hard_drop SHALL enter HARD, priority over any same-cycle step.
REQ-026 HARD: move_down asserted every cycle while can_down=1; can_down=0 -> LOCK.
REQ-027 GROUNDED: can_down=1 -> FALL (lock counter reset); else fall_tick increments counter; LOCK when count reaches LOCK_TICKS; hard_drop -> LOCK.
REQ-028 LOCK SHALL pulse lock_piece exactly one cycle, then CLEAR.
REQ-029 CLEAR waits clear_done; adds lines_cleared to 5-bit level-line accumulator, -> IDLE.
REQ-030 Accumulator >= LINES_PER_LEVEL SHALL subtract LINES_PER_LEVEL and level++ (saturate 15) in same update.
REQ-031 Each level-up SHALL add SPEED_STEP to Fall_Count, saturating at FALL_MAX, no wrap.
REQ-032 OVER absorbing until Reset; move_down, lock_piece held 0; spawn/hard_drop ignored.
REQ-033 Inputs outside current state's listed set SHALL be ignored.

Reset
REQ-034 Reset SHALL asynchronously force IDLE, counters 0, level 0, Fall_Count 0, game_over 0, move_down 0, lock_piece 0, including mid-HARD or mid-GROUNDED.

Configuration
REQ-035 Macro FALL_SCHEDULER_HARD_DROP_EN defined: HARD state and hard_drop behaviour per REQ-025-027.
REQ-036 Undefined: HARD absent, hard_drop ignored everywhere, port retained.

Verification
REQ-037 spawn, can_down=1, 3 fall_tick -> 3 move_down pulses, each one cycle after its tick.
REQ-038 can_down=0 at step, LOCK_TICKS=8 -> lock_piece on 8th subsequent fall_tick; can_down=1 at tick 5 -> back to FALL, no lock.
REQ-039 soft_drop held 12 clocks, SOFT_DIV=4, no fall_tick -> 3 move_down pulses.
REQ-040 hard_drop with can_down high 5 cycles -> 5 consecutive move_down, then one lock_piece; macro off -> none.
REQ-041 clear_done with lines_cleared=4 three times -> level=1, Fall_Count=7, accumulator=2; repeat to 11 levels -> Fall_Count=75.
REQ-042 spawn with can_down=0 -> game_over=1 sticky; Reset -> game_over=0, IDLE.
